can_irq_debug_gen: RTL and testbench
====================================

Name: can_irq_debug_gen

Overview:
Producer side of the Canakari debug/interrupt signal bundle. Collects one-cycle event pulses from the CAN controller core: successful transmit, successful receive and status change. Holds them as sticky pending flags with per-source enables and software acknowledge. Drives the registered debug outputs (irq, irqstatus, irqsuctra, irqsucrec, Prescale_EN_debug, statedeb, bitst) that testbench monitors and the host observe.

Parameters:
HOLDOFF_CYCLES, 4, cycles out_irq is forced low after any acknowledge (0 = no holdoff)
IRQ_EN_RST, 3'b000, reset value of the interrupt enable register {status, sucrec, suctra}
OVR_W, 4, width of per-source overrun counters (optional feature)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
evt_suctra  in  1  one-cycle pulse: frame transmitted successfully
evt_sucrec  in  1  one-cycle pulse: frame received successfully
evt_status  in  1  one-cycle pulse: error/status change
ctrl_state  in  8  current controller FSM state code
bit_cnt  in  7  current bit-stream position
prescale_en  in  1  prescaler enable strobe from bit timing
cfg_we  in  1  write strobe for enable register
cfg_wdata  in  3  new enables {status, sucrec, suctra}
ack_valid  in  1  acknowledge strobe
ack_bits  in  3  pending bits to clear {status, sucrec, suctra}
irq_en  out  3  current enable register
out_irq  out  1  combined interrupt request
out_irqstatus  out  1  pending flag, status
out_irqsuctra  out  1  pending flag, transmit success
out_irqsucrec  out  1  pending flag, receive success
out_Prescale_EN_debug  out  1  registered prescale_en
out_statedeb  out  8  registered ctrl_state
out_bitst  out  7  registered bit_cnt
ovr_cnt  out  3*OVR_W  overrun counters {status, sucrec, suctra}

Behaviour:
- Reset (async, active-high): all pending = 0; out_irq = 0; out_statedeb = 8'h00; out_bitst = 0; out_Prescale_EN_debug = 0; irq_en = IRQ_EN_RST; holdoff counter = 0; ovr_cnt = 0. Reset mid-operation discards all pending events immediately.
- Pending bit p[i] next value:
  - Set if evt[i].
  - Otherwise cleared if ack_valid & ack_bits[i].
  - Otherwise held.
  - Same-cycle event and ack on the same bit: the event wins, and p[i] stays 1.
- Flag outputs are the pending registers themselves: event in cycle N gives the flag high in N+1. Flags are independent of irq_en.
- cfg_we in cycle N: irq_en updates in N+1. The new enables are used when computing out_irq for N+1.
- Holdoff:
  - Any ack_valid loads the counter with HOLDOFF_CYCLES. Otherwise the counter decrements to 0 and saturates there.
  - Holdoff is active while the counter is nonzero, including the cycle the load is registered.
- out_irq registered = |(p_next & en_next) & (hold_next == 0). Event at N with the enable set and no holdoff gives out_irq = 1 at N+1.
- Level output: out_irq stays high until every enabled pending bit is cleared, or holdoff starts.
- Debug passthrough: out_statedeb, out_bitst and out_Prescale_EN_debug are 1-cycle registered copies, with no filtering.
- ack_valid with ack_bits = 0 clears nothing but still starts holdoff.

Optional Feature:
CAN_IRQ_OVERRUN_CNT_EN
- Defined: ovr_cnt[i] increments when evt[i] arrives while p[i] = 1 and the bit is not acked in the same cycle. It saturates at 2^OVR_W-1. It clears to 0 on ack_valid & ack_bits[i] with no simultaneous evt[i].
- Undefined: ovr_cnt is tied to 0 and no counter flops are inferred.

Decomposition:
- Package can_debug_pkg holds:
  - bit index constants IRQ_SUCTRA = 0, IRQ_SUCREC = 1, IRQ_STATUS = 2;
  - typedef irq_vec_t (logic [2:0]);
  - statedeb width constant STATEDEB_W = 8.
- Sub-module can_irq_holdoff: loadable down-counter with active flag, parameterised by HOLDOFF_CYCLES.

Test Plan:
- Reset check: reset high for 3 cycles, then low -> all outputs 0, irq_en = 3'b000. Then ctrl_state = 8'h2A -> out_statedeb = 8'h2A one cycle later.
- Basic interrupt and ack: irq_en = 3'b001, evt_suctra at N -> out_irqsuctra = 1 and out_irq = 1 at N+1. Ack 3'b001 at M -> flag 0 and out_irq 0 at M+1.
- Masked source: irq_en = 3'b001, evt_sucrec -> out_irqsucrec = 1 and out_irq stays 0. Then write irq_en = 3'b011 -> out_irq = 1 on the next cycle.
- Event/ack collision: evt_status and ack_bits = 3'b100 in the same cycle -> out_irqstatus stays 1.
- Holdoff: HOLDOFF_CYCLES = 4, ack 3'b001 while sucrec is pending and enabled -> out_irq low for 4 cycles, then high again.
- Overrun (macro defined, OVR_W = 4): 20 evt_suctra pulses without ack -> ovr_cnt[3:0] = 15 (saturated). Ack -> 0.

Source files
------------

// File: rtl/can_debug_pkg.sv
// rtl/can_debug_pkg.sv - shared bit indices and types for the CAN interrupt/debug bundle
package can_debug_pkg;
    localparam int IRQ_SUCTRA = 0;
    localparam int IRQ_SUCREC = 1;
    localparam int IRQ_STATUS = 2;
    localparam int STATEDEB_W = 8;

    typedef logic [2:0] irq_vec_t;
endpackage

// File: rtl/can_irq_holdoff.sv
// rtl/can_irq_holdoff.sv - loadable saturating down-counter that masks the interrupt after an acknowledge
module can_irq_holdoff #(
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    output logic active_d_o
);
    localparam int CW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(HOLDOFF_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Next-state view so the interrupt register sees holdoff in the same cycle the load lands.
    assign active_d_o = (cnt_d != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/can_irq_debug_gen.sv
// rtl/can_irq_debug_gen.sv - sticky CAN event flags, masked interrupt with holdoff, debug copies; option CAN_IRQ_OVERRUN_CNT_EN
module can_irq_debug_gen
    import can_debug_pkg::*;
#(
    parameter int       HOLDOFF_CYCLES = 4,
    parameter logic [2:0] IRQ_EN_RST   = 3'b000,
    parameter int       OVR_W          = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  evt_suctra,
    input  logic                  evt_sucrec,
    input  logic                  evt_status,
    input  logic [STATEDEB_W-1:0] ctrl_state,
    input  logic [6:0]            bit_cnt,
    input  logic                  prescale_en,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_wdata,
    input  logic                  ack_valid,
    input  logic [2:0]            ack_bits,
    output logic [2:0]            irq_en,
    output logic                  out_irq,
    output logic                  out_irqstatus,
    output logic                  out_irqsuctra,
    output logic                  out_irqsucrec,
    output logic                  out_Prescale_EN_debug,
    output logic [STATEDEB_W-1:0] out_statedeb,
    output logic [6:0]            out_bitst,
    output logic [3*OVR_W-1:0]    ovr_cnt
);
    irq_vec_t evt;
    irq_vec_t ack_mask;
    irq_vec_t pend_q, pend_d;
    irq_vec_t en_q, en_d;
    logic     irq_q;
    logic     hold_active_d;
    logic                  prescale_q;
    logic [STATEDEB_W-1:0] state_q;
    logic [6:0]            bitst_q;

    always_comb begin
        evt             = '0;
        evt[IRQ_SUCTRA] = evt_suctra;
        evt[IRQ_SUCREC] = evt_sucrec;
        evt[IRQ_STATUS] = evt_status;
    end

    assign ack_mask = ack_valid ? ack_bits : '0;
    // Event has priority over a same-cycle acknowledge of the same bit.
    assign pend_d   = evt | (pend_q & ~ack_mask);
    assign en_d     = cfg_we ? cfg_wdata : en_q;

    can_irq_holdoff #(
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_holdoff (
        .clock      (clock),
        .reset      (reset),
        .load_i     (ack_valid),
        .active_d_o (hold_active_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q     <= '0;
            en_q       <= IRQ_EN_RST;
            irq_q      <= 1'b0;
            prescale_q <= 1'b0;
            state_q    <= '0;
            bitst_q    <= '0;
        end else begin
            pend_q     <= pend_d;
            en_q       <= en_d;
            irq_q      <= (|(pend_d & en_d)) & ~hold_active_d;
            prescale_q <= prescale_en;
            state_q    <= ctrl_state;
            bitst_q    <= bit_cnt;
        end
    end

`ifdef CAN_IRQ_OVERRUN_CNT_EN
    logic [OVR_W-1:0] ovr_q [3];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) ovr_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (evt[i] && pend_q[i] && !ack_mask[i]) begin
                    if (ovr_q[i] != '1) ovr_q[i] <= ovr_q[i] + 1'b1;
                end else if (ack_mask[i] && !evt[i]) begin
                    ovr_q[i] <= '0;
                end
            end
        end
    end

    assign ovr_cnt = {ovr_q[IRQ_STATUS], ovr_q[IRQ_SUCREC], ovr_q[IRQ_SUCTRA]};
`else
    assign ovr_cnt = '0;
`endif

    assign irq_en                = en_q;
    assign out_irq               = irq_q;
    assign out_irqsuctra         = pend_q[IRQ_SUCTRA];
    assign out_irqsucrec         = pend_q[IRQ_SUCREC];
    assign out_irqstatus         = pend_q[IRQ_STATUS];
    assign out_Prescale_EN_debug = prescale_q;
    assign out_statedeb          = state_q;
    assign out_bitst             = bitst_q;
endmodule

// File: tb/tb_can_irq_debug_gen.sv
// tb/tb_can_irq_debug_gen.sv - table-driven scoreboard bench for can_irq_debug_gen
module tb_can_irq_debug_gen;
    localparam int OVR_W = 4;

    logic clock = 1'b0;
    logic reset;
    logic evt_suctra, evt_sucrec, evt_status;
    logic [7:0] ctrl_state;
    logic [6:0] bit_cnt;
    logic prescale_en;
    logic cfg_we;
    logic [2:0] cfg_wdata;
    logic ack_valid;
    logic [2:0] ack_bits;
    logic [2:0] irq_en;
    logic out_irq, out_irqstatus, out_irqsuctra, out_irqsucrec, out_Prescale_EN_debug;
    logic [7:0] out_statedeb;
    logic [6:0] out_bitst;
    logic [3*OVR_W-1:0] ovr_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    can_irq_debug_gen #(
        .HOLDOFF_CYCLES (4),
        .IRQ_EN_RST     (3'b000),
        .OVR_W          (OVR_W)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .evt_suctra            (evt_suctra),
        .evt_sucrec            (evt_sucrec),
        .evt_status            (evt_status),
        .ctrl_state            (ctrl_state),
        .bit_cnt               (bit_cnt),
        .prescale_en           (prescale_en),
        .cfg_we                (cfg_we),
        .cfg_wdata             (cfg_wdata),
        .ack_valid             (ack_valid),
        .ack_bits              (ack_bits),
        .irq_en                (irq_en),
        .out_irq               (out_irq),
        .out_irqstatus         (out_irqstatus),
        .out_irqsuctra         (out_irqsuctra),
        .out_irqsucrec         (out_irqsucrec),
        .out_Prescale_EN_debug (out_Prescale_EN_debug),
        .out_statedeb          (out_statedeb),
        .out_bitst             (out_bitst),
        .ovr_cnt               (ovr_cnt)
    );

    typedef struct {
        logic [2:0] evt;
        logic       ack_v;
        logic [2:0] ack_b;
        logic       we;
        logic [2:0] wd;
        logic [2:0] flg;
        logic       irq;
        logic [2:0] en;
    } vec_t;

    typedef struct {
        logic [2:0] flg;
        logic       irq;
        logic [2:0] en;
    } exp_t;

    vec_t tbl[31];
    exp_t sb[$];

    function automatic vec_t mk(logic [2:0] e, logic av, logic [2:0] ab, logic w, logic [2:0] d,
                                logic [2:0] f, logic i, logic [2:0] n);
        vec_t v;
        v.evt = e; v.ack_v = av; v.ack_b = ab; v.we = w; v.wd = d;
        v.flg = f; v.irq = i; v.en = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] flags();
        return {out_irqstatus, out_irqsucrec, out_irqsuctra};
    endfunction

    task automatic idle_inputs();
        {evt_status, evt_sucrec, evt_suctra} = 3'b000;
        ack_valid = 1'b0; ack_bits = 3'b000;
        cfg_we = 1'b0; cfg_wdata = 3'b000;
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        {evt_status, evt_sucrec, evt_suctra} = v.evt;
        ack_valid = v.ack_v; ack_bits = v.ack_b;
        cfg_we = v.we; cfg_wdata = v.wd;
        e.flg = v.flg; e.irq = v.irq; e.en = v.en;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check($sformatf("sb_empty[%0d]", idx), 0, 1);
        end else begin
            e = sb.pop_front();
            check($sformatf("flags[%0d]", idx), 32'(flags()), 32'(e.flg));
            check($sformatf("irq[%0d]", idx), 32'(out_irq), 32'(e.irq));
            check($sformatf("irq_en[%0d]", idx), 32'(irq_en), 32'(e.en));
        end
    endtask

    initial begin
        //        evt    av ackb  we wd      flg    irq en
        tbl[0]  = mk(3'b000, 0, 3'b000, 1, 3'b001, 3'b000, 0, 3'b001);
        tbl[1]  = mk(3'b001, 0, 3'b000, 0, 3'b000, 3'b001, 1, 3'b001);
        tbl[2]  = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b001, 1, 3'b001);
        tbl[3]  = mk(3'b000, 1, 3'b001, 0, 3'b000, 3'b000, 0, 3'b001);
        tbl[4]  = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b000, 0, 3'b001);
        tbl[5]  = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b000, 0, 3'b001);
        tbl[6]  = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b000, 0, 3'b001);
        tbl[7]  = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b000, 0, 3'b001);
        tbl[8]  = mk(3'b010, 0, 3'b000, 0, 3'b000, 3'b010, 0, 3'b001);
        tbl[9]  = mk(3'b000, 0, 3'b000, 1, 3'b011, 3'b010, 1, 3'b011);
        tbl[10] = mk(3'b100, 1, 3'b100, 0, 3'b000, 3'b110, 0, 3'b011);
        tbl[11] = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b110, 0, 3'b011);
        tbl[12] = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b110, 0, 3'b011);
        tbl[13] = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b110, 0, 3'b011);
        tbl[14] = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b110, 1, 3'b011);
        tbl[15] = mk(3'b000, 1, 3'b000, 0, 3'b000, 3'b110, 0, 3'b011);
        tbl[16] = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b110, 0, 3'b011);
        tbl[17] = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b110, 0, 3'b011);
        tbl[18] = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b110, 0, 3'b011);
        tbl[19] = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b110, 1, 3'b011);
        tbl[20] = mk(3'b000, 0, 3'b000, 1, 3'b111, 3'b110, 1, 3'b111);
        tbl[21] = mk(3'b000, 1, 3'b010, 0, 3'b000, 3'b100, 0, 3'b111);
        tbl[22] = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b100, 0, 3'b111);
        tbl[23] = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b100, 0, 3'b111);
        tbl[24] = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b100, 0, 3'b111);
        tbl[25] = mk(3'b000, 0, 3'b000, 0, 3'b000, 3'b100, 1, 3'b111);
        tbl[26] = mk(3'b000, 1, 3'b100, 0, 3'b000, 3'b000, 0, 3'b111);
        tbl[27] = mk(3'b000, 0, 3'b000, 1, 3'b000, 3'b000, 0, 3'b000);
        tbl[28] = mk(3'b111, 0, 3'b000, 0, 3'b000, 3'b111, 0, 3'b000);
        tbl[29] = mk(3'b001, 1, 3'b111, 0, 3'b000, 3'b001, 0, 3'b000);
        tbl[30] = mk(3'b000, 1, 3'b001, 0, 3'b000, 3'b000, 0, 3'b000);

        reset = 1'b1;
        idle_inputs();
        ctrl_state = 8'h00; bit_cnt = 7'h00; prescale_en = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_flags", 32'(flags()), 0);
        check("rst_irq", 32'(out_irq), 0);
        check("rst_en", 32'(irq_en), 0);
        check("rst_state", 32'(out_statedeb), 0);
        check("rst_bitst", 32'(out_bitst), 0);
        check("rst_presc", 32'(out_Prescale_EN_debug), 0);
        check("rst_ovr", 32'(ovr_cnt), 0);

        ctrl_state = 8'h2A; bit_cnt = 7'h55; prescale_en = 1'b1;
        @(posedge clock); #1;
        check("dbg_state_2a", 32'(out_statedeb), 32'h2A);
        check("dbg_bitst_55", 32'(out_bitst), 32'h55);
        check("dbg_presc_1", 32'(out_Prescale_EN_debug), 1);
        ctrl_state = 8'h81; bit_cnt = 7'h7F; prescale_en = 1'b0;
        @(posedge clock); #1;
        check("dbg_state_81", 32'(out_statedeb), 32'h81);
        check("dbg_bitst_7f", 32'(out_bitst), 32'h7F);
        check("dbg_presc_0", 32'(out_Prescale_EN_debug), 0);

        for (int i = 0; i < 31; i++) apply(tbl[i], i);
        idle_inputs();

        // Overrun: 20 back-to-back transmit events, then acknowledge.
        for (int i = 0; i < 20; i++) begin
            evt_suctra = 1'b1;
            @(posedge clock); #1;
        end
        evt_suctra = 1'b0;
`ifdef CAN_IRQ_OVERRUN_CNT_EN
        check("ovr_sat", 32'(ovr_cnt[3:0]), 15);
`else
        check("ovr_tied", 32'(ovr_cnt), 0);
`endif
        check("ovr_others", 32'(ovr_cnt[3*OVR_W-1:OVR_W]), 0);
        check("ovr_flag", 32'(out_irqsuctra), 1);
        ack_valid = 1'b1; ack_bits = 3'b001;
        @(posedge clock); #1;
        idle_inputs();
        check("ovr_clr", 32'(ovr_cnt), 0);
        check("ovr_flag_clr", 32'(out_irqsuctra), 0);

        // Asynchronous reset in mid-operation drops pending state without a clock edge.
        cfg_we = 1'b1; cfg_wdata = 3'b100; evt_status = 1'b1;
        @(posedge clock); #1;
        idle_inputs();
        repeat (4) @(posedge clock);
        #1;
        check("pre_rst_flag", 32'(out_irqstatus), 1);
        check("pre_rst_irq", 32'(out_irq), 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_flag", 32'(out_irqstatus), 0);
        check("async_rst_irq", 32'(out_irq), 0);
        check("async_rst_en", 32'(irq_en), 0);
        check("async_rst_state", 32'(out_statedeb), 0);
        @(posedge clock); #1 reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
